// File: rtl/imm_gen_pipe_if.sv
// Shared decode types and the handshake bundle for imm_gen_pipe.
// The slave modport is the generator's view; the master modport is the fetch/decode/ID-EX side.
package imm_gen_pipe_pkg;
  typedef logic [31:0] instruction_t;

  typedef enum logic [2:0] {
    I_TYPE   = 3'd0,
    S_TYPE   = 3'd1,
    B_TYPE   = 3'd2,
    U_TYPE   = 3'd3,
    J_TYPE   = 3'd4,
    R_TYPE   = 3'd5,
    RSVD6    = 3'd6,
    RSVD7    = 3'd7
  } encoding_t;
endpackage

interface imm_gen_pipe_if
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  instruction_t     instruction;
  encoding_t        control_encoding;
  logic             zimm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_enc_err;

  modport slave (
    input  flush, in_valid, instruction, control_encoding, zimm_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_enc_err
  );

  modport master (
    output flush, in_valid, instruction, control_encoding, zimm_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_enc_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator (I/S/B/U/J/Z) behind a valid/ready handshake with flush.
// Define IMM_GEN_PIPE_SKID_EN to add a one-entry skid buffer and register in_ready.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  function automatic entry_t form_entry(input instruction_t     inst,
                                        input encoding_t        enc,
                                        input logic             zsel,
                                        input logic [TAG_W-1:0] tag);
    entry_t e;
    e.imm = '0;
    e.tag = tag;
    e.err = 1'b0;
    case (enc)
      I_TYPE: begin
        if (zsel) e.imm = XLEN'(inst[19:15]);
        else      e.imm = XLEN'($signed(inst[31:20]));
      end
      S_TYPE: e.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      B_TYPE: e.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      // U stays sign-extended above bit 31 so RV64 LUI gets the correct upper half.
      U_TYPE: e.imm = XLEN'($signed({inst[31:12], 12'h000}));
      J_TYPE: e.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  entry_t new_entry;
  logic   in_xfer;
  logic   out_vld_q, out_vld_d;
  entry_t out_q, out_d;

  assign new_entry = form_entry(bus.instruction, bus.control_encoding, bus.zimm_sel, bus.in_tag);
  assign in_xfer   = bus.in_valid && bus.in_ready;

`ifdef IMM_GEN_PIPE_SKID_EN
  logic   skid_vld_q, skid_vld_d;
  entry_t skid_q, skid_d;

  assign bus.in_ready = !skid_vld_q;

  // The skid entry is always older than anything arriving, so it drains first.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (bus.flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || bus.out_ready) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        out_vld_d = 1'b1;
        out_d     = new_entry;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_vld_d = 1'b1;
      skid_d     = new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end
`else
  logic out_xfer;

  assign bus.in_ready = !out_vld_q || bus.out_ready;
  assign out_xfer     = out_vld_q && bus.out_ready;

  // Flush outranks a same-cycle accept: the accepted input is dropped.
  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (bus.flush) begin
      out_vld_d = 1'b0;
    end else if (in_xfer) begin
      out_vld_d = 1'b1;
      out_d     = new_entry;
    end else if (out_xfer) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end
`endif

  assign bus.out_valid   = out_vld_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_tag     = out_q.tag;
  assign bus.out_enc_err = out_q.err;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. Extracts and sign-extends the I/S/B/U/J immediates from a 32-bit instruction to XLEN bits. Also produces the CSR zero-extended uimm (Z form) and flags unsupported encodings. Sits between fetch/decode and the ID/EX register behind a valid/ready handshake, with flush support.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (PC or decode bundle) carried alongside the instruction.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block accepts this cycle.
- instruction  input  instruction_t (32)  raw instruction.
- control_encoding  input  encoding_t  format selector (I/S/B/U/J/other).
- zimm_sel  input  1  with I_TYPE: emit zero-extended instruction[19:15] instead of the I immediate.
- in_tag  input  TAG_W  passthrough sideband.
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  immediate.
- out_tag  output  TAG_W  tag captured with the instruction.
- out_enc_err  output  1  control_encoding was not I/S/B/U/J; out_imm is 0.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Immediate formation, with s = instruction[31]:
  - I: {s×(XLEN-12), inst[31:20]}.
  - S: {s×(XLEN-12), inst[31:25], inst[11:7]}.
  - B: {s×(XLEN-13), inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {s×(XLEN-32), inst[31:12], 12'b0}. This matches RV64 LUI semantics.
  - J: {s×(XLEN-21), inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Z (I_TYPE and zimm_sel): {0×(XLEN-5), inst[19:15]}.
- zimm_sel is ignored for any encoding other than I_TYPE.
- Other encodings: out_imm = 0 and out_enc_err = 1. The entry still flows through the pipeline; it is not dropped.
- Immediate, tag and error flag are computed combinationally and captured together on in-transfer.
- Output stage, no skid:
  - in_ready = !out_valid || out_ready.
  - Simultaneous in-transfer and out-transfer replaces the held entry, keeping full throughput.
- flush:
  - Clears out_valid (and the skid entry, when present) on the next edge.
  - flush wins over a simultaneous in-transfer: the input is consumed and discarded.
  - in_ready is unaffected by flush.
- Outputs are stable while out_valid && !out_ready. No data change is allowed under backpressure.

## Timing
- Latency: 1 cycle from in-transfer to out_valid.
- Throughput: 1 per cycle when out_ready is held high.
- Reset (async assert, sync-safe release):
  - out_valid = 0, out_imm = 0, out_tag = 0, out_enc_err = 0.
  - Skid entry empty.
  - in_ready = 1 from the first cycle after reset release.
- Reset mid-operation discards every held entry; no output transfer occurs on the reset edge.
- out_imm, out_tag and out_enc_err are don't-care while out_valid = 0. The bench must not check them then.
- Without skid, in_ready has a combinational path from out_ready.

## Configuration
- IMM_GEN_PIPE_SKID_EN defined:
  - Adds a one-entry skid buffer behind the output register.
  - in_ready becomes a pure register output: in_ready = !skid_valid.
  - This removes the out_ready → in_ready combinational path.
  - When the output stalls and an input arrives, the input lands in the skid entry.
  - When the output drains, the skid entry moves to the output register next cycle, preserving order.
  - Full throughput is sustained; capacity is 2 entries.
- IMM_GEN_PIPE_SKID_EN undefined: single output register, behaviour as in Operation.

## Test plan
- XLEN=32, I_TYPE, 0xFFF00093 (addi x1,x0,-1) → out_imm 0xFFFFFFFF one cycle later. With XLEN=64 → 0xFFFFFFFFFFFFFFFF.
- U_TYPE 0x12345037 → 0x12345000. J_TYPE 0xFF9FF06F → 0xFFFFFFF8 (−8). B_TYPE 0xFE000EE3 → 0xFFFFFFFC (−4).
- I_TYPE with zimm_sel=1, inst 0x3402D073 (rs1 field = 5) → 0x00000005. The same inst with zimm_sel=0 → 0x00000340.
- Encoding R_TYPE → out_imm 0, out_enc_err 1, entry still delivered in order with its in_tag.
- Backpressure: stream 4 tagged instructions with out_ready low for 3 cycles:
  - Outputs hold steady while stalled.
  - No loss or duplication; tags emerge in order.
  - With skid: in_ready drops only after 2 entries are held.
- flush asserted together with in_valid while out_valid=1 → out_valid=0 next cycle, flushed input never appears. rst asserted mid-stream → out_valid=0 immediately (async).
